// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter feeding NREQ local clients onto one
// APB bus. It steps through the IDLE/SETUP/ACCESS phases and guards ACCESS
// with a pready timeout. Each completion goes back to the client that owns
// the transfer.
module apb_req_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              prst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [AW-1:0]     paddr,
  output logic [DW-1:0]     pwdata,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DW-1:0]     prdata
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [AW-1:0]     paddr_q, paddr_d;
  logic [DW-1:0]     pwdata_q, pwdata_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              grant_any;
  logic [PW-1:0]     grant_idx;
  logic [NREQ-1:0]   grant_vec;
  logic              sel_write;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_wdata;
  int unsigned       cand;

  // Round-robin search starting just past the last winner, plus field mux
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(rr_ptr_q) + k) % NREQ;
      if (!grant_any && req_valid[cand[PW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[PW-1:0];
      end
    end
    grant_vec            = '0;
    grant_vec[grant_idx] = grant_any;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned c = 0; c < NREQ; c++) begin
      if (grant_idx == PW'(c)) begin
        sel_write = req_write[c];
        sel_addr  = req_addr[c*AW +: AW];
        sel_wdata = req_wdata[c*DW +: DW];
      end
    end
  end

  // Grant is combinational so the accept lands in the IDLE cycle itself;
  // it is masked while reset is held so every output reads zero then.
  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && prst_n)
      req_ready = grant_vec;
  end

  // Next-state logic for the protocol sequencer and its registered outputs
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (grant_any) begin
          owner_d   = grant_idx;
          rr_ptr_d  = grant_idx;
          pwrite_d  = sel_write;
          paddr_d   = sel_addr;
          pwdata_d  = sel_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        // pready wins over the timeout when both land on the same edge
        if (pready) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = pwrite_q ? '0 : prdata;
          rsp_err_d            = pslverr;
          psel_d               = 1'b0;
          penable_d            = 1'b0;
          cnt_d                = '0;
          state_d              = ST_IDLE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = '0;
          rsp_err_d            = 1'b1;
          psel_d               = 1'b0;
          penable_d            = 1'b0;
          cnt_d                = '0;
          state_d              = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= PW'(NREQ - 1);
      owner_q     <= '0;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter (NREQ=2, AW=8, DW=32, TIMEOUT=16).
module tb_apb_req_arbiter;

  logic        pclk;
  logic        prst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;

  int n_checks = 0;
  int n_errors = 0;

  apb_req_arbiter #(
    .NREQ(2),
    .AW(8),
    .DW(32),
    .TIMEOUT(16)
  ) dut (
    .pclk(pclk),
    .prst_n(prst_n),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
    .paddr(paddr),
    .pwdata(pwdata),
    .pready(pready),
    .pslverr(pslverr),
    .prdata(prdata)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here
  task automatic nxt;
    @(posedge pclk);
    #2;
  endtask

  logic [1:0] exp_g [4];

  initial begin
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    prst_n = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;

    // Reset state
    nxt; #1;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    nxt; prst_n = 1'b1;

    // Single write, no wait
    nxt;
    req_valid = 2'b01; req_write = 2'b01; req_addr[7:0] = 8'h04;
    req_wdata[31:0] = 32'hDEADBEEF; pready = 1'b1;
    #1;
    chk("t1_ready_c0", req_ready, 2'b01);
    chk("t1_psel_c0", psel, 0);
    nxt; req_valid = '0; #1;
    chk("t1_psel_c1", psel, 1);
    chk("t1_penable_c1", penable, 0);
    chk("t1_paddr_c1", paddr, 8'h04);
    chk("t1_pwrite_c1", pwrite, 1);
    chk("t1_pwdata_c1", pwdata, 32'hDEADBEEF);
    chk("t1_ready_c1", req_ready, 0);
    nxt; #1;
    chk("t1_penable_c2", penable, 1);
    chk("t1_rsp_valid_c2", rsp_valid, 0);
    nxt; #1;
    chk("t1_rsp_valid_c3", rsp_valid, 2'b01);
    chk("t1_rsp_err_c3", rsp_err, 0);
    chk("t1_rsp_rdata_c3", rsp_rdata, 0);
    chk("t1_psel_c3", psel, 0);

    // Read with two wait states from client 1
    nxt;
    req_valid = 2'b10; req_write = 2'b00; req_addr[15:8] = 8'h10; pready = 1'b0;
    #1;
    chk("t2_ready_c0", req_ready, 2'b10);
    nxt; req_valid = '0; #1;
    chk("t2_paddr_c1", paddr, 8'h10);
    chk("t2_psel_c1", psel, 1);
    nxt; #1;
    chk("t2_penable_c2", penable, 1);
    chk("t2_paddr_c2", paddr, 8'h10);
    chk("t2_rsp_valid_c2", rsp_valid, 0);
    nxt; #1;
    chk("t2_paddr_c3", paddr, 8'h10);
    chk("t2_rsp_valid_c3", rsp_valid, 0);
    nxt; pready = 1'b1; prdata = 32'h12345678; #1;
    chk("t2_paddr_c4", paddr, 8'h10);
    chk("t2_rsp_valid_c4", rsp_valid, 0);
    nxt; pready = 1'b0; prdata = '0; #1;
    chk("t2_rsp_valid_c5", rsp_valid, 2'b10);
    chk("t2_rsp_rdata_c5", rsp_rdata, 32'h12345678);
    chk("t2_rsp_err_c5", rsp_err, 0);
    chk("t2_psel_c5", psel, 0);
    nxt; #1;
    chk("t2_rsp_valid_c6", rsp_valid, 0);
    chk("t2_rdata_hold", rsp_rdata, 32'h12345678);

    // Contention: both clients request continuously
    nxt;
    req_valid = 2'b11; req_write = 2'b11;
    req_addr[7:0] = 8'h50; req_addr[15:8] = 8'h60; pready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      #1;
      chk("t3_grant", req_ready, exp_g[t]);
      if (t > 0) chk("t3_rsp_owner", rsp_valid, exp_g[t-1]);
      nxt; #1;
      chk("t3_ready_setup", req_ready, 0);
      chk("t3_paddr", paddr, (exp_g[t] == 2'b01) ? 8'h50 : 8'h60);
      nxt; #1;
      chk("t3_ready_access", req_ready, 0);
      nxt;
    end
    req_valid = '0; #1;
    chk("t3_rsp_last", rsp_valid, 2'b10);
    chk("t3_ready_last", req_ready, 0);

    // Slave error on a read, then a clean write
    nxt;
    req_valid = 2'b01; req_write = 2'b00; req_addr[7:0] = 8'h20;
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hCAFEF00D;
    #1;
    chk("t4_ready", req_ready, 2'b01);
    nxt; req_valid = '0;
    nxt;
    nxt; #1;
    chk("t4_rsp_valid", rsp_valid, 2'b01);
    chk("t4_rsp_err", rsp_err, 1);
    chk("t4_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
    nxt;
    pslverr = 1'b0; req_valid = 2'b10; req_write = 2'b10; req_addr[15:8] = 8'h30;
    #1;
    chk("t4b_ready", req_ready, 2'b10);
    nxt; req_valid = '0;
    nxt;
    nxt; #1;
    chk("t4b_rsp_valid", rsp_valid, 2'b10);
    chk("t4b_rsp_err", rsp_err, 0);
    chk("t4b_rsp_rdata", rsp_rdata, 0);

    // Timeout: pready never rises
    nxt;
    req_valid = 2'b01; req_write = 2'b00; req_addr[7:0] = 8'h40; pready = 1'b0;
    prdata = 32'hFFFF0000;
    #1;
    chk("t5_ready", req_ready, 2'b01);
    nxt; req_valid = '0;
    nxt;
    for (int k = 0; k <= 16; k++) begin
      #1;
      chk("t5_penable_wait", penable, 1);
      chk("t5_rsp_wait", rsp_valid, 0);
      nxt;
    end
    #1;
    chk("t5_rsp_valid", rsp_valid, 2'b01);
    chk("t5_rsp_err", rsp_err, 1);
    chk("t5_rsp_rdata", rsp_rdata, 0);
    chk("t5_psel", psel, 0);
    nxt; #1;
    chk("t5_psel_after", psel, 0);
    chk("t5_penable_after", penable, 0);

    // pready on the same edge the counter hits the limit completes normally
    nxt;
    req_valid = 2'b10; req_write = 2'b00; req_addr[15:8] = 8'h44;
    #1;
    chk("t5b_ready", req_ready, 2'b10);
    nxt; req_valid = '0;
    nxt;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("t5b_rsp_wait", rsp_valid, 0);
      nxt;
    end
    pready = 1'b1; prdata = 32'h000055AA; #1;
    chk("t5b_penable_last", penable, 1);
    nxt; pready = 1'b0; prdata = '0; #1;
    chk("t5b_rsp_valid", rsp_valid, 2'b10);
    chk("t5b_rsp_err", rsp_err, 0);
    chk("t5b_rsp_rdata", rsp_rdata, 32'h000055AA);

    // Reset during ACCESS
    nxt;
    req_valid = 2'b01; req_write = 2'b00; req_addr[7:0] = 8'h08;
    #1;
    chk("t6_ready", req_ready, 2'b01);
    nxt; req_valid = '0;
    nxt; #1;
    chk("t6_penable_pre", penable, 1);
    req_valid = 2'b11; prst_n = 1'b0; #1;
    chk("t6_psel", psel, 0);
    chk("t6_penable", penable, 0);
    chk("t6_paddr", paddr, 0);
    chk("t6_req_ready", req_ready, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_rsp_rdata", rsp_rdata, 0);
    chk("t6_rsp_err", rsp_err, 0);
    nxt; #1;
    chk("t6_rsp_valid_hold", rsp_valid, 0);
    chk("t6_psel_hold", psel, 0);
    nxt; prst_n = 1'b1; #1;
    chk("t6_first_grant", req_ready, 2'b01);
    chk("t6_rsp_valid_rel", rsp_valid, 0);
    nxt; req_valid = '0;
    nxt;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
